// File: rtl/cache_trace_feeder.sv
// Trace buffer that replays loaded (address, opcode) entries into the cache request port.
// Latency: first request valid 2 cycles after start is sampled, then >= 2 cycles per entry.
// Backpressure: request held stable while cache_ready is low; illegal opcodes skipped without a handshake.
module cache_trace_feeder #(
    parameter int ADDR_W = 48,
    parameter int OP_W   = 8,
    parameter int DEPTH  = 128,
    parameter int PTR_W  = 7,
    parameter int CNT_W  = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [OP_W-1:0]     load_op,
    input  logic                clear,
    input  logic                start,
    input  logic                cache_ready,
    output logic                cache_valid,
    output logic [ADDR_W-1:0]   cache_addr,
    output logic [OP_W-1:0]     cache_op,
    output logic                load_full,
    output logic                busy,
    output logic                done,
    output logic [PTR_W:0]      entry_count,
    output logic [CNT_W-1:0]    issued_reads,
    output logic [CNT_W-1:0]    issued_writes,
    output logic [CNT_W-1:0]    bad_ops
);

    localparam logic [OP_W-1:0] OP_RD = OP_W'(8'h52);
    localparam logic [OP_W-1:0] OP_WR = OP_W'(8'h57);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

    state_t                   state, state_nxt;
    logic [ADDR_W+OP_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic                     op_legal, handshake, consume, last_entry;
    logic                     mem_we, run_start;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign load_full = (entry_count == (PTR_W+1)'(DEPTH));

    always_comb begin
        op_legal    = (cache_op == OP_RD) || (cache_op == OP_WR);
        cache_valid = (state == ISSUE) && op_legal;
        handshake   = cache_valid && cache_ready;
        // an illegal entry retires in its ISSUE cycle regardless of cache_ready
        consume     = (state == ISSUE) && (!op_legal || cache_ready);
        last_entry  = ({1'b0, rd_ptr} == entry_count - (PTR_W+1)'(1));
        run_start   = (state == IDLE) && !clear && start && (entry_count != '0);
        mem_we      = (state == IDLE) && !reset && !clear && !start && load_en && !load_full;

        state_nxt = state;
        case (state)
            IDLE:    if (!clear && start) state_nxt = (entry_count == '0) ? DONE : FETCH;
            FETCH:   state_nxt = ISSUE;
            ISSUE:   if (consume) state_nxt = last_entry ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr] <= {load_addr, load_op};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            entry_count   <= '0;
            cache_addr    <= '0;
            cache_op      <= '0;
            issued_reads  <= '0;
            issued_writes <= '0;
            bad_ops       <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (clear) begin
                    wr_ptr      <= '0;
                    entry_count <= '0;
                end else if (run_start) begin
                    rd_ptr        <= '0;
                    issued_reads  <= '0;
                    issued_writes <= '0;
                    bad_ops       <= '0;
                end else if (mem_we) begin
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                    entry_count <= entry_count + (PTR_W+1)'(1);
                end
            end
            // the RAM read port registers straight into the request outputs
            if (state == FETCH) {cache_addr, cache_op} <= mem[rd_ptr];
            if (consume && !last_entry) rd_ptr <= rd_ptr + PTR_W'(1);
            if (handshake) begin
                if (cache_op == OP_RD) issued_reads  <= sat_inc(issued_reads);
                else                   issued_writes <= sat_inc(issued_writes);
            end
            if ((state == ISSUE) && !op_legal) bad_ops <= sat_inc(bad_ops);
        end
    end

endmodule
